// File: rtl/fifo_push_arbiter_if.sv
// Purpose: bundles the producer-side request bus, shared-FIFO push/pop strobes and head-owner report.
// Latency: none, wires only.
// Backpressure: req_ready is the per-requester grant; fifo_full/fifo_pop gate it inside the arbiter.
//
// Ports (via modports):
//   master - producers/consumer side: drives req_valid, req_data, fifo_full, fifo_pop, flush
//   slave  - arbiter side: drives req_ready, fifo_push, fifo_data_in, head_valid, head_id
interface fifo_push_arbiter_if #(
    parameter int NUM_REQ    = 3,
    parameter int DATA_WIDTH = 32,
    parameter int ID_W       = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
);
    logic [NUM_REQ-1:0]            req_valid;
    logic [NUM_REQ*DATA_WIDTH-1:0] req_data;
    logic [NUM_REQ-1:0]            req_ready;
    logic                          fifo_push;
    logic [DATA_WIDTH-1:0]         fifo_data_in;
    logic                          fifo_full;
    logic                          fifo_pop;
    logic                          head_valid;
    logic [ID_W-1:0]               head_id;
    logic                          flush;

    modport master (
        output req_valid, req_data, fifo_full, fifo_pop, flush,
        input  req_ready, fifo_push, fifo_data_in, head_valid, head_id
    );

    modport slave (
        input  req_valid, req_data, fifo_full, fifo_pop, flush,
        output req_ready, fifo_push, fifo_data_in, head_valid, head_id
    );
endinterface

// File: rtl/fifo_push_arbiter.sv
// Purpose: round-robin arbiter sharing one FIFO between NUM_REQ producers, tagging entries with source ID.
// Latency: grant is combinational (0 cycles); head_valid/head_id follow a push by one cycle.
// Backpressure: no grant while the FIFO is full without a same-cycle pop, or the requester is at its cap.
//
// Ports:
//   clk  - clock
//   rst  - asynchronous active-high reset; combinational outputs are forced to 0 while it is high
//   bus  - fifo_push_arbiter_if.slave: requester valid/data/ready, FIFO push/data/full/pop,
//          head owner report (head_valid/head_id) and synchronous flush
module fifo_push_arbiter #(
    parameter int NUM_REQ         = 3,
    parameter int FIFO_DEPTH      = 4,
    parameter int DATA_WIDTH      = 32,
    parameter int MAX_OUTSTANDING = 2
) (
    input  logic                clk,
    input  logic                rst,
    fifo_push_arbiter_if.slave  bus
);
    localparam int ID_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
    localparam int OUT_W = $clog2(MAX_OUTSTANDING + 1);

    localparam logic [ID_W-1:0]  RR_RESET = ID_W'(NUM_REQ - 1);
    localparam logic [OUT_W-1:0] OUT_MAX  = OUT_W'(MAX_OUTSTANDING);
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(FIFO_DEPTH);
    localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(FIFO_DEPTH - 1);

    logic [ID_W-1:0]    rr_ptr;
    logic [ID_W-1:0]    tag_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]   head_ptr;
    logic [PTR_W-1:0]   tail_ptr;
    logic [CNT_W-1:0]   tag_count;
    logic [OUT_W-1:0]   outstanding [NUM_REQ];

    logic               head_valid_int;
    logic [ID_W-1:0]    head_tag;
    logic               pop_eff;
    logic               space;
    logic               push;
    logic               found;
    logic [ID_W-1:0]    winner;
    logic [ID_W-1:0]    idx;
    logic [NUM_REQ-1:0] pop_credit;
    logic [NUM_REQ-1:0] eligible;
    logic [NUM_REQ-1:0] win_oh;
    logic [NUM_REQ-1:0] grant;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_LAST) ? '0 : p + 1'b1;
    endfunction

    assign head_valid_int = (tag_count != '0);
    assign head_tag       = tag_mem[head_ptr];

    // A pop during flush is dropped; a pop on an empty queue is illegal and also dropped.
    assign pop_eff = bus.fifo_pop & head_valid_int & ~bus.flush;
    assign space   = ~bus.fifo_full | bus.fifo_pop;

    // The entry being popped this cycle frees its owner's slot immediately, so a
    // requester sitting at its cap can be granted in the same cycle its head leaves.
    always_comb begin
        pop_credit = '0;
        eligible   = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            pop_credit[i] = pop_eff && (head_tag == ID_W'(i));
            eligible[i]   = bus.req_valid[i] &&
                            ((outstanding[i] < OUT_MAX) || pop_credit[i]);
        end
    end

    // Round-robin search starting one past the last winner.
    always_comb begin
        win_oh = '0;
        winner = '0;
        found  = 1'b0;
        idx    = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            idx = ID_W'((int'(rr_ptr) + k) % NUM_REQ);
            if (!found && eligible[idx]) begin
                found       = 1'b1;
                win_oh[idx] = 1'b1;
                winner      = idx;
            end
        end
    end

    assign grant = (found && space && !bus.flush && !rst) ? win_oh : '0;
    assign push  = |grant;

    always_comb begin
        bus.fifo_data_in = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant[i]) begin
                bus.fifo_data_in = bus.req_data[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    assign bus.req_ready  = grant;
    assign bus.fifo_push  = push;
    assign bus.head_valid = head_valid_int & ~rst;
    // Stale tags stay in memory after a flush, so the ID is masked when the queue is empty.
    assign bus.head_id    = (head_valid_int && !rst) ? head_tag : '0;

    // Tag queue: circular buffer of source IDs in FIFO order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head_ptr  <= '0;
            tail_ptr  <= '0;
            tag_count <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                tag_mem[i] <= '0;
            end
        end else if (bus.flush) begin
            head_ptr  <= '0;
            tail_ptr  <= '0;
            tag_count <= '0;
        end else begin
            if (push) begin
                tag_mem[tail_ptr] <= winner;
                tail_ptr          <= ptr_inc(tail_ptr);
            end
            if (pop_eff) begin
                head_ptr <= ptr_inc(head_ptr);
            end
            case ({push, pop_eff})
                2'b10:   tag_count <= tag_count + 1'b1;
                2'b01:   tag_count <= tag_count - 1'b1;
                default: tag_count <= tag_count;
            endcase
        end
    end

    // Per-requester occupancy of the shared FIFO.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                outstanding[i] <= '0;
            end
        end else if (bus.flush) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                outstanding[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_REQ; i++) begin
                case ({grant[i], pop_credit[i]})
                    2'b10:   outstanding[i] <= outstanding[i] + 1'b1;
                    2'b01:   outstanding[i] <= outstanding[i] - 1'b1;
                    default: outstanding[i] <= outstanding[i];
                endcase
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rr_ptr <= RR_RESET;
        end else if (bus.flush) begin
            rr_ptr <= RR_RESET;
        end else if (push) begin
            rr_ptr <= winner;
        end
    end

    a_pop_needs_head: assert property (@(posedge clk) disable iff (rst)
        bus.fifo_pop |-> head_valid_int);

    a_tag_count_bound: assert property (@(posedge clk) disable iff (rst)
        tag_count <= CNT_MAX);

    a_no_push_when_full: assert property (@(posedge clk) disable iff (rst)
        !(push && bus.fifo_full && !bus.fifo_pop));
endmodule
